// File: rtl/pack.sv
// Packet framer: buffers one full payload of parallel words, then serializes it (optionally behind a 32-bit sync word).
// Latency: the first output chunk is valid in the cycle after the edge that accepts the last payload word.
// Backpressure: input is refused while draining; the output holds o_data/o_valid steady while i_ready_output is low.
//
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_data/i_valid_input/o_ready    : payload word input handshake (accepted only while filling)
//   o_data/o_valid/i_ready_output   : narrow output stream handshake
// Build option: define PACK_PREAMBLE_EN to prefix every packet with PREAMBLE (MSB-first).
// Without it the packet is payload only.
module pack #(
    parameter int          SIZE_BIT_PACK   = 1976,
    parameter int          SIZE_INPUT_BIT  = 8,
    parameter int          SIZE_OUTPUT_BIT = 1,
    parameter logic [31:0] PREAMBLE        = 32'hCF80AA31
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    output logic                       o_ready,
    input  logic [SIZE_INPUT_BIT-1:0]  i_data,
    input  logic                       i_valid_input,
    input  logic                       i_ready_output,
    output logic [SIZE_OUTPUT_BIT-1:0] o_data,
    output logic                       o_valid
);

    localparam int W   = SIZE_BIT_PACK / SIZE_INPUT_BIT;
    localparam int CPW = SIZE_INPUT_BIT / SIZE_OUTPUT_BIT;
    localparam int AW  = (W > 1) ? $clog2(W) : 1;
    localparam int CW  = (CPW > 1) ? $clog2(CPW) : 1;

    localparam logic [AW-1:0] LAST_WORD  = AW'(W - 1);
    localparam logic [CW-1:0] LAST_CHUNK = CW'(CPW - 1);

`ifdef PACK_PREAMBLE_EN
    localparam int            PCH      = 32 / SIZE_OUTPUT_BIT;
    localparam int            PW       = (PCH > 1) ? $clog2(PCH) : 1;
    localparam logic [PW-1:0] LAST_PRE = PW'(PCH - 1);
`endif

    typedef enum logic [1:0] {
        ST_FILL     = 2'd0,
`ifdef PACK_PREAMBLE_EN
        ST_PREAMBLE = 2'd1,
`endif
        ST_PAYLOAD  = 2'd2
    } state_t;

    state_t              state;
    logic [AW-1:0]       wr_addr;
    logic [AW-1:0]       rd_word;
    logic [CW-1:0]       rd_chunk;
`ifdef PACK_PREAMBLE_EN
    logic [PW-1:0]       pre_cnt;
`endif

    // Single bank: filling and draining never overlap, so one write and one read port suffice.
    logic [SIZE_INPUT_BIT-1:0] mem [W];

    logic [AW-1:0]              nxt_word;
    logic [CW-1:0]              nxt_chunk;
    logic                       last_chunk;
    logic                       last_word;
    logic [SIZE_OUTPUT_BIT-1:0] nxt_dat;
    logic                       wr_en;

    // Chunk c of a word, counted from the MSB end.
    function automatic logic [SIZE_OUTPUT_BIT-1:0] chunk_of(input logic [SIZE_INPUT_BIT-1:0] w,
                                                            input logic [CW-1:0] c);
        logic [SIZE_INPUT_BIT-1:0] s;
        s = w << (int'(c) * SIZE_OUTPUT_BIT);
        return s[SIZE_INPUT_BIT-1 -: SIZE_OUTPUT_BIT];
    endfunction

    // Chunk n of the sync word, counted from the MSB end.
    function automatic logic [SIZE_OUTPUT_BIT-1:0] preamble_chunk(input int n);
        logic [31:0] s;
        s = PREAMBLE << (n * SIZE_OUTPUT_BIT);
        return s[31 -: SIZE_OUTPUT_BIT];
    endfunction

    assign wr_en = (state == ST_FILL) && i_valid_input && o_ready;

    // Read pointer look-ahead: o_data is registered, so the chunk after the
    // current one is fetched combinationally and loaded on each transfer.
    always_comb begin
        last_chunk = (rd_chunk == LAST_CHUNK);
        last_word  = (rd_word == LAST_WORD);
        nxt_chunk  = rd_chunk + CW'(1);
        nxt_word   = rd_word;
        if (last_chunk) begin
            nxt_chunk = '0;
            nxt_word  = last_word ? '0 : rd_word + AW'(1);
        end
        nxt_dat = chunk_of(mem[nxt_word], nxt_chunk);
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= ST_FILL;
            wr_addr  <= '0;
            rd_word  <= '0;
            rd_chunk <= '0;
`ifdef PACK_PREAMBLE_EN
            pre_cnt  <= '0;
`endif
            o_ready  <= 1'b0;
            o_valid  <= 1'b0;
            o_data   <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    o_ready <= 1'b1;
                    if (wr_en) begin
                        if (wr_addr == LAST_WORD) begin
                            // Last word: stop accepting and present the first chunk on the same edge.
                            wr_addr <= '0;
                            o_ready <= 1'b0;
                            o_valid <= 1'b1;
`ifdef PACK_PREAMBLE_EN
                            state   <= ST_PREAMBLE;
                            pre_cnt <= '0;
                            o_data  <= preamble_chunk(0);
`else
                            state   <= ST_PAYLOAD;
                            // A one-word packet has its only word still on i_data this edge.
                            o_data  <= chunk_of((wr_addr == '0) ? i_data : mem[0], '0);
`endif
                        end else begin
                            wr_addr <= wr_addr + AW'(1);
                        end
                    end
                end
`ifdef PACK_PREAMBLE_EN
                ST_PREAMBLE: begin
                    if (i_ready_output) begin
                        if (pre_cnt == LAST_PRE) begin
                            state   <= ST_PAYLOAD;
                            pre_cnt <= '0;
                            o_data  <= chunk_of(mem[0], '0);
                        end else begin
                            pre_cnt <= pre_cnt + PW'(1);
                            o_data  <= preamble_chunk(int'(pre_cnt) + 1);
                        end
                    end
                end
`endif
                ST_PAYLOAD: begin
                    if (i_ready_output) begin
                        if (last_chunk && last_word) begin
                            state    <= ST_FILL;
                            rd_word  <= '0;
                            rd_chunk <= '0;
                            o_valid  <= 1'b0;
                            o_ready  <= 1'b1;
                            o_data   <= '0;
                        end else begin
                            rd_word  <= nxt_word;
                            rd_chunk <= nxt_chunk;
                            o_data   <= nxt_dat;
                        end
                    end
                end
                default: begin
                    state   <= ST_FILL;
                    o_ready <= 1'b0;
                    o_valid <= 1'b0;
                    o_data  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pack.sv
// Bench for pack: drives word fills and chunk drains; every accepted word pushes its
// expected chunks (behind the sync word when enabled) onto a queue popped on each transfer.
// Handshake expectations (o_ready/o_valid) come from a small cycle model kept in step().
module tb_pack;

    localparam int IB  = 8;
    localparam int OB  = 1;
    localparam int NB  = 1976;
    localparam int W   = NB / IB;
    localparam int CPW = IB / OB;
`ifdef PACK_PREAMBLE_EN
    localparam int PRE_CH = 32 / OB;
`else
    localparam int PRE_CH = 0;
`endif
    localparam int          TOTAL = W * CPW + PRE_CH;
    localparam logic [31:0] SYNC  = 32'hCF80AA31;

    logic          i_clk;
    logic          i_reset;
    logic          o_ready;
    logic [IB-1:0] i_data;
    logic          i_valid_input;
    logic          i_ready_output;
    logic [OB-1:0] o_data;
    logic          o_valid;

    pack #(
        .SIZE_BIT_PACK   (NB),
        .SIZE_INPUT_BIT  (IB),
        .SIZE_OUTPUT_BIT (OB),
        .PREAMBLE        (SYNC)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .o_ready        (o_ready),
        .i_data         (i_data),
        .i_valid_input  (i_valid_input),
        .i_ready_output (i_ready_output),
        .o_data         (o_data),
        .o_valid        (o_valid)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int            checks = 0;
    int            errors = 0;
    logic [OB-1:0] exp_q[$];
    bit            m_ready;
    bit            m_tx;
    int            m_words;
    int            m_left;
    int            n_obs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: called #1 after a rising edge; checks outputs against the model,
    // applies inputs, predicts what the coming edge does, then advances to #1 after it.
    task automatic step(input logic rdy, input logic vld, input logic [IB-1:0] dat, output bit acc);
        bit          nr;
        bit          nt;
        logic [31:0] s;
        logic [IB-1:0] w;
        i_ready_output = rdy;
        i_valid_input  = vld;
        i_data         = dat;
        acc = 1'b0;
        nr  = m_ready;
        nt  = m_tx;
        chk("o_ready", 32'(o_ready), 32'(m_ready));
        chk("o_valid", 32'(o_valid), 32'(m_tx));
        if (!m_tx) begin
            chk("o_data_idle", 32'(o_data), 32'd0);
        end else begin
            chk("o_data", 32'(o_data), 32'(exp_q[0]));
        end
        if (o_valid && rdy) n_obs++;
        if (!m_ready && !m_tx) nr = 1'b1;
        if (m_tx && rdy) begin
            void'(exp_q.pop_front());
            m_left--;
            if (m_left == 0) begin
                nt = 1'b0;
                nr = 1'b1;
            end
        end
        if (m_ready && vld) begin
            acc = 1'b1;
            if (m_words == 0) begin
                n_obs = 0;
                for (int i = 0; i < PRE_CH; i++) begin
                    s = SYNC << (i * OB);
                    exp_q.push_back(s[31 -: OB]);
                end
            end
            for (int c = 0; c < CPW; c++) begin
                w = dat << (c * OB);
                exp_q.push_back(w[IB-1 -: OB]);
            end
            m_words++;
            if (m_words == W) begin
                m_words = 0;
                nr = 1'b0;
                nt = 1'b1;
                m_left = TOTAL;
            end
        end
        m_ready = nr;
        m_tx    = nt;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset        = 1'b0;
        i_valid_input  = 1'b0;
        i_ready_output = 1'b0;
        i_data         = '0;
        #2;
        chk("rst_o_ready", 32'(o_ready), 32'd0);
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_data", 32'(o_data), 32'd0);
        exp_q.delete();
        m_ready = 1'b0;
        m_tx    = 1'b0;
        m_words = 0;
        m_left  = 0;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
    endtask

    task automatic fill(input int base, input int stepv);
        int k = 0;
        int guard = 0;
        bit acc;
        while (k < W && guard < 4 * W) begin
            step(1'b1, 1'b1, IB'(base + k * stepv), acc);
            if (acc) k++;
            guard++;
        end
        chk("fill_words", 32'(k), 32'(W));
    endtask

    // pat 0: ready held high; pat 1: ready pattern 1-0-0. Stops after stop_after transfers.
    task automatic drain(input int pat, input int stop_after);
        int cyc = 0;
        bit acc;
        logic r;
        while (m_tx && (TOTAL - m_left) < stop_after && cyc < 4 * TOTAL + 16) begin
            r = (pat == 0) ? 1'b1 : ((cyc % 3) == 0);
            step(r, 1'b0, '0, acc);
            cyc++;
        end
        if (stop_after >= TOTAL) begin
            chk("drain_done", 32'(m_tx), 32'd0);
            chk("xfer_count", 32'(n_obs), 32'(TOTAL));
        end
    endtask

    initial begin
        bit acc;
        int total;
        int guard;

        // Reset, then idle with sparse ready pulses.
        do_reset();
        for (int i = 0; i < 120; i++) step((i % 3) == 0, 1'b0, '0, acc);

        // Ramp payload, continuous drain.
        fill(0, 1);
        drain(0, TOTAL);

        // Valid held high across two packets and their drains.
        total = 0;
        guard = 0;
        while (total < 2 * W && guard < 3 * (W + TOTAL)) begin
            step(1'b1, 1'b1, IB'(total * 3 + 1), acc);
            if (acc) total++;
            guard++;
        end
        chk("cont_words", 32'(total), 32'(2 * W));
        drain(0, TOTAL);

        // Drain with ready toggling 1-0-0.
        fill(7, 5);
        drain(1, TOTAL);

        // Reset after 100 payload chunks, then a fresh packet.
        fill(5, 11);
        drain(0, PRE_CH + 100);
        chk("mid_left", 32'(m_left), 32'(TOTAL - PRE_CH - 100));
        do_reset();
        step(1'b1, 1'b0, '0, acc);
        fill(0, 1);
        drain(0, TOTAL);

        // All-ones payload.
        fill(255, 0);
        drain(0, TOTAL);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pack.md
# pack

Packet framer: buffers one fixed-size payload arriving as parallel words, then serializes it behind a 32-bit sync preamble as a narrow output stream. It sits between the byte-oriented data source and the bit-serial modulator. Both sides use a valid/ready handshake. Transmission starts only once a complete payload is buffered.

## Interface
- SIZE_BIT_PACK, 1976: payload length in bits; multiple of SIZE_INPUT_BIT.
- SIZE_INPUT_BIT, 8: input word width.
- SIZE_OUTPUT_BIT, 1: output chunk width; divides SIZE_INPUT_BIT and 32.
- PREAMBLE, 32'hCF80AA31: sync word.
- i_clk  in  1  single clock, all logic on rising edge.
- i_reset  in  1  reset, asynchronous, active-low.
- o_ready  out  1  input side may transfer a word.
- i_data  in  SIZE_INPUT_BIT  payload word.
- i_valid_input  in  1  i_data valid.
- i_ready_output  in  1  downstream accepts a chunk.
- o_data  out  SIZE_OUTPUT_BIT  output chunk.
- o_valid  out  1  o_data valid.

## Operation
- Words per packet: W = SIZE_BIT_PACK/SIZE_INPUT_BIT (247). Payload chunks: SIZE_BIT_PACK/SIZE_OUTPUT_BIT (1976). Preamble chunks: 32/SIZE_OUTPUT_BIT (32).
- States: FILL, PREAMBLE, PAYLOAD.
- FILL:
  - o_ready=1, o_valid=0, o_data=0.
  - Input word accepted on an edge with i_valid_input && o_ready; stored at the write address, which then increments.
  - On acceptance of word W-1, go to PREAMBLE.
- PREAMBLE:
  - o_ready=0, o_valid=1.
  - o_data presents PREAMBLE MSB-first, SIZE_OUTPUT_BIT bits per transfer.
  - After the last preamble chunk transfers, go to PAYLOAD.
- PAYLOAD:
  - o_ready=0, o_valid=1.
  - Words are sent in arrival order, each word MSB-first.
  - After the last chunk transfers, go to FILL; all counters clear.
- Output transfer occurs on an edge with o_valid && i_ready_output. o_data and o_valid hold stable while i_ready_output=0.
- i_valid_input outside FILL is ignored; no word is lost or overwritten.
- Buffer: W x SIZE_INPUT_BIT storage, single bank, no overlap of fill and drain.

## Timing
- Reset (i_reset=0, asynchronous): state FILL, counters 0, o_ready=0, o_valid=0, o_data=0.
- The first edge after reset release sets o_ready=1.
- All outputs are registered.
- Input-to-output latency: the edge accepting word W-1 clears o_ready and sets o_valid with the first preamble chunk. The first chunk is therefore visible in the next cycle, and no extra word can be accepted.
- Throughput: one chunk per cycle with i_ready_output held high. A full packet takes 2008 transfers at the 1-bit default.
- The edge transferring the final payload chunk clears o_valid and sets o_ready in the same edge.
- Reset asserted mid-operation aborts the packet immediately. The partial payload is discarded and the block returns to FILL.
- i_ready_output in FILL has no effect.

## Configuration
- PACK_PREAMBLE_EN:
  - Defined: PREAMBLE state included; every packet is prefixed by the 32-bit sync word.
  - Undefined: PREAMBLE state and its counter are compiled out. FILL goes directly to PAYLOAD; the packet is payload only (1976 transfers).

## Test plan
- Reset, then 40 pulses of i_ready_output (1 cycle high, 2 low) with i_valid_input=0 -> o_valid=0, o_data=0 throughout, o_ready=1 from the first cycle after reset release.
- Stream 247 bytes 0x00..0xF6 with i_ready_output=1 -> first 32 o_data bits are 1100_1111_1000_0000_1010_1010_0011_0001, then 0x00..0xF6 MSB-first; o_valid drops after transfer 2008; o_ready returns high on the same edge.
- i_valid_input held high through the full packet and drain -> exactly 247 words accepted per packet; word 248 becomes word 0 of the next packet.
- Drain the packet with i_ready_output toggled 1-0-0 -> o_data holds on low cycles; the bit sequence is identical to the continuous case.
- i_reset=0 after 100 payload bits -> o_valid=0 and o_ready=0 immediately; o_ready=1 after release; the next packet starts with the preamble.
- PACK_PREAMBLE_EN undefined, 247 bytes 0xFF -> 1976 ones, no preamble, o_valid high for exactly 1976 transfers.
